message_arbiter: RTL and testbench

- Round-robin arbiter sharing the single packet_merger message input among NUM_SOURCES requesters.
- Each requester presents a full MESSAGE_LENGTH-bit message on a valid/ready handshake.
- The arbiter selects one requester, registers its message into an output stage and drives packet_merger's message valid/ready/data interface.
- It also keeps saturating per-source accepted-message counters for coverage and debug readback.

---
 rtl/message_arbiter_if.sv | 25 ++
 rtl/message_arbiter.sv | 132 +++++++++++++
 tb/tb_message_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/message_arbiter_if.sv
// rtl/message_arbiter_if.sv - source-side and packet_merger-side handshake bundle for message_arbiter
interface message_arbiter_if #(
   parameter int NUM_SOURCES    = 4,
   parameter int MESSAGE_LENGTH = 48,
   parameter int SRC_BITS       = $clog2(NUM_SOURCES)
);
   logic [NUM_SOURCES-1:0]                src_valid;
   logic [NUM_SOURCES-1:0]                src_ready;
   logic [NUM_SOURCES*MESSAGE_LENGTH-1:0] src_data;
   logic [NUM_SOURCES-1:0]                src_enable;
   logic                                  msg_valid;
   logic                                  msg_ready;
   logic [MESSAGE_LENGTH-1:0]             msg_data;
   logic [SRC_BITS-1:0]                   msg_source;

   modport master (
      input  src_valid, src_data, src_enable, msg_ready,
      output src_ready, msg_valid, msg_data, msg_source
   );

   modport slave (
      output src_valid, src_data, src_enable, msg_ready,
      input  src_ready, msg_valid, msg_data, msg_source
   );
endinterface

// File: rtl/message_arbiter.sv
// rtl/message_arbiter.sv - round-robin arbiter feeding one registered message stage to packet_merger
// Also keeps saturating per-source accepted-message counters for debug readback.
module message_arbiter #(
   parameter int NUM_SOURCES    = 4,
   parameter int MESSAGE_LENGTH = 48,
   parameter int COUNT_WIDTH    = 16,
   parameter int SRC_BITS       = $clog2(NUM_SOURCES)
) (
   input  logic                   clk,
   input  logic                   reset,
   message_arbiter_if.master      bus,
   input  logic [SRC_BITS-1:0]    stat_sel,
   output logic [COUNT_WIDTH-1:0] stat_count,
   input  logic                   stat_clear,
   output logic                   busy
);
   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_t                    state;
   state_t                    state_next;
   logic [SRC_BITS-1:0]       pointer;
   logic [SRC_BITS-1:0]       winner;
   logic [SRC_BITS:0]         idx;
   logic                      found;
   logic                      accept;
   logic [NUM_SOURCES-1:0]    eligible;
   logic [NUM_SOURCES-1:0]    grant;
   logic [MESSAGE_LENGTH-1:0] winner_data;
   logic [MESSAGE_LENGTH-1:0] data_q;
   logic [SRC_BITS-1:0]       source_q;
   logic [COUNT_WIDTH-1:0]    count [NUM_SOURCES];

   assign eligible = bus.src_valid & bus.src_enable;

   // Search starts at the pointer and wraps; idx carries one extra bit for the wrap test.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_SOURCES; k++) begin
         idx = {1'b0, pointer} + (SRC_BITS+1)'(k);
         if (idx >= (SRC_BITS+1)'(NUM_SOURCES)) begin
            idx = idx - (SRC_BITS+1)'(NUM_SOURCES);
         end
         if (!found && eligible[idx[SRC_BITS-1:0]]) begin
            found  = 1'b1;
            winner = idx[SRC_BITS-1:0];
         end
      end
   end

   always_comb begin
      winner_data = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (winner == SRC_BITS'(i)) begin
            winner_data = bus.src_data[i*MESSAGE_LENGTH +: MESSAGE_LENGTH];
         end
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               accept     = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            if (bus.msg_ready) begin
               accept     = found;
               state_next = found ? SEND : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Gating with reset keeps src_ready low for the whole time reset is held.
   assign grant = (accept && reset) ? ({{(NUM_SOURCES-1){1'b0}}, 1'b1} << winner) : '0;

   assign bus.src_ready  = grant;
   assign bus.msg_valid  = (state == SEND);
   assign bus.msg_data   = data_q;
   assign bus.msg_source = source_q;
   assign busy           = (state == SEND) || (|eligible);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pointer  <= '0;
         data_q   <= '0;
         source_q <= '0;
      end else if (accept) begin
         pointer  <= (winner == SRC_BITS'(NUM_SOURCES-1)) ? '0 : winner + 1'b1;
         data_q   <= winner_data;
         source_q <= winner;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SOURCES; i++) count[i] <= '0;
      end else if (stat_clear) begin
         for (int i = 0; i < NUM_SOURCES; i++) count[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            if (bus.src_valid[i] && grant[i] && count[i] != COUNT_MAX) begin
               count[i] <= count[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (stat_sel == SRC_BITS'(i)) stat_count = count[i];
      end
   end
endmodule

// File: tb/tb_message_arbiter.sv
// tb/tb_message_arbiter.sv - scoreboard bench for message_arbiter with a behavioural round-robin model
module tb_message_arbiter;
   localparam int N  = 4;
   localparam int ML = 48;
   localparam int CW = 4;
   localparam int SB = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [SB-1:0] stat_sel;
   logic [CW-1:0] stat_count;
   logic          stat_clear;
   logic          busy;

   int checks = 0;
   int errors = 0;

   logic [SB+ML-1:0] exp_q[$];
   int               m_ptr;
   bit               m_valid;
   int               m_count[N];

   message_arbiter_if #(.NUM_SOURCES(N), .MESSAGE_LENGTH(ML), .SRC_BITS(SB)) bus ();

   message_arbiter #(
      .NUM_SOURCES(N), .MESSAGE_LENGTH(ML), .COUNT_WIDTH(CW), .SRC_BITS(SB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .stat_sel(stat_sel),
      .stat_count(stat_count),
      .stat_clear(stat_clear),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      logic [63:0] r;
      for (int i = 0; i < N; i++) begin
         r = {$urandom(), $urandom()};
         bus.src_data[i*ML +: ML] = r[ML-1:0];
      end
   endtask

   // Reference model: evaluated on the falling edge with the inputs that the next rising edge will see.
   always @(negedge clk) begin : model
      logic [N-1:0] elig;
      logic [N-1:0] exp_ready;
      int           win;
      bit           acc;
      if (!reset) begin
         m_ptr   = 0;
         m_valid = 0;
         for (int i = 0; i < N; i++) m_count[i] = 0;
         exp_q.delete();
      end else begin
         elig = bus.src_valid & bus.src_enable;
         win  = -1;
         for (int k = 0; k < N; k++) begin
            if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         end
         acc       = (win >= 0) && (!m_valid || bus.msg_ready);
         exp_ready = acc ? (N'(1) << win) : '0;
         check("src_ready", bus.src_ready, exp_ready);
         check("msg_valid", bus.msg_valid, m_valid);
         check("busy", busy, m_valid || (elig != 0));
         check("stat_count", stat_count, m_count[stat_sel]);
         if (acc) begin
            exp_q.push_back({SB'(win), bus.src_data[win*ML +: ML]});
            m_ptr = (win + 1) % N;
         end
         if (stat_clear) begin
            for (int i = 0; i < N; i++) m_count[i] = 0;
         end else if (acc && m_count[win] < (1 << CW) - 1) begin
            m_count[win]++;
         end
         m_valid = acc || (m_valid && !bus.msg_ready);
      end
   end

   always @(negedge clk) begin : monitor
      logic [SB+ML-1:0] e;
      if (reset && bus.msg_valid && bus.msg_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL msg_unexpected: got source %0d data %0h expected no message", bus.msg_source, bus.msg_data);
         end else begin
            e = exp_q.pop_front();
            check("msg_source", bus.msg_source, e[SB+ML-1:ML]);
            check("msg_data", bus.msg_data, e[ML-1:0]);
         end
      end
   end

   initial begin
      bus.src_valid  = '1;
      bus.src_enable = '1;
      bus.src_data   = '0;
      bus.msg_ready  = 1'b1;
      stat_sel       = '0;
      stat_clear     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_src_ready", bus.src_ready, 0);
      check("rst_msg_valid", bus.msg_valid, 0);
      check("rst_msg_data", bus.msg_data, 0);
      check("rst_msg_source", bus.msg_source, 0);
      check("rst_stat_count", stat_count, 0);
      reset         = 1'b1;
      bus.src_valid = '0;
      bus.msg_ready = 1'b0;
      step();

      // single source
      bus.src_valid          = 4'b0001;
      bus.src_data[0 +: ML]  = 48'h0102_0304_0506;
      bus.msg_ready          = 1'b1;
      @(negedge clk);
      check("single_ready", bus.src_ready, 4'b0001);
      step();
      bus.src_valid = '0;
      @(negedge clk);
      check("single_valid", bus.msg_valid, 1);
      check("single_data", bus.msg_data, 48'h010203040506);
      check("single_source", bus.msg_source, 0);
      check("single_count", stat_count, 1);
      step();

      // fairness
      stat_clear = 1'b1;
      step();
      stat_clear    = 1'b0;
      bus.src_valid = '1;
      for (int c = 0; c < 8; c++) begin
         rand_data();
         step();
      end
      bus.src_valid = '0;
      for (int s = 0; s < N; s++) begin
         stat_sel = SB'(s);
         @(negedge clk);
         check("fair_count", stat_count, 2);
         step();
      end

      // backpressure
      bus.src_valid = '1;
      bus.msg_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         rand_data();
         step();
      end
      bus.msg_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", bus.src_ready != 0, 1);
      step();

      // enable masking
      stat_clear = 1'b1;
      step();
      stat_clear     = 1'b0;
      bus.src_enable = 4'b1010;
      for (int c = 0; c < 8; c++) begin
         rand_data();
         step();
      end
      bus.src_valid = '0;
      for (int s = 0; s < N; s++) begin
         stat_sel = SB'(s);
         @(negedge clk);
         check("mask_count", stat_count, (s % 2) ? 4 : 0);
         step();
      end
      bus.src_enable = '1;

      // saturation and clear-wins
      stat_clear = 1'b1;
      step();
      stat_clear    = 1'b0;
      stat_sel      = 2'd2;
      bus.src_valid = 4'b0100;
      for (int c = 0; c < 17; c++) begin
         rand_data();
         step();
      end
      bus.src_valid = '0;
      @(negedge clk);
      check("sat_count", stat_count, 15);
      step();
      bus.src_valid = 4'b0100;
      stat_clear    = 1'b1;
      step();
      bus.src_valid = '0;
      stat_clear    = 1'b0;
      @(negedge clk);
      check("clear_wins", stat_count, 0);
      step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         bus.src_valid  = N'($urandom());
         bus.src_enable = N'($urandom() | $urandom());
         bus.msg_ready  = ($urandom_range(0, 3) != 0);
         stat_clear     = ($urandom_range(0, 40) == 0);
         stat_sel       = SB'($urandom());
         rand_data();
         step();
      end
      stat_clear     = 1'b0;
      bus.src_enable = '1;

      // reset while holding a message
      bus.src_valid = 4'b0001;
      bus.msg_ready = 1'b0;
      step();
      step();
      bus.msg_ready = 1'b1;
      bus.src_valid = '1;
      #2;
      reset = 1'b0;
      #1;
      check("rst_mid_valid", bus.msg_valid, 0);
      check("rst_mid_ready", bus.src_ready, 0);
      step();
      step();
      reset         = 1'b1;
      bus.src_valid = '0;
      for (int s = 0; s < N; s++) begin
         stat_sel = SB'(s);
         @(negedge clk);
         check("rst_mid_count", stat_count, 0);
         step();
      end
      bus.src_valid = '1;
      @(negedge clk);
      check("rst_mid_pointer", bus.src_ready, 4'b0001);
      step();

      // drain
      bus.src_valid = '0;
      bus.msg_ready = 1'b1;
      repeat (4) step();
      check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
